wormhole_port_arbiter: RTL and testbench

- Per-output-port packet scheduler for the 5-port router. One instance per output port (L, N, E, W, S).
- Shares the output port between the five input FIFOs using round-robin allocation at packet granularity.
- Locks the port to the winning input for the whole wormhole packet and counts flits down to release.
- Drives the FIFO read-enable grants and the one-hot crossbar select for its output.

---
 rtl/wormhole_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_wormhole_port_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wormhole_port_arbiter.sv
// Output-port scheduler for the 5-port wormhole router: round-robin choice among
// header flits, then the port stays locked to the winner until the packet drains.
module wormhole_port_arbiter #(
    parameter logic [2:0] HEADER_ID = 3'b001,
    parameter logic [2:0] TAIL_ID   = 3'b100,
    parameter int         LEN_W     = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         req,
    input  logic [14:0]        flit_id,
    input  logic [5*LEN_W-1:0] len,
    input  logic               out_ready,
    output logic [4:0]         grant,
    output logic [4:0]         sel,
    output logic               busy,
    output logic               pkt_done
);

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_n;
    logic [2:0]       owner_r, owner_n;
    logic [2:0]       last_owner_r, last_n;
    logic [LEN_W-1:0] cnt_r, cnt_n;
    logic             pkt_done_r, done_n;

    logic [4:0]       eligible_s;
    logic             found_s;
    logic [2:0]       winner_s;
    logic [2:0]       cand_s;
    logic [LEN_W-1:0] winner_len_s;
    logic [2:0]       owner_flit_s;
    logic [4:0]       owner_oh_s;
    logic             owner_req_s;
    logic [4:0]       grant_s;

    function automatic logic [4:0] onehot5(input logic [2:0] idx);
        logic [4:0] oh;
        case (idx)
            3'd0:    oh = 5'b00001;
            3'd1:    oh = 5'b00010;
            3'd2:    oh = 5'b00100;
            3'd3:    oh = 5'b01000;
            3'd4:    oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx >= 3'd4) ? 3'd0 : idx + 3'd1;
    endfunction

    // Header eligibility and round-robin winner search starting after last_owner
    always_comb begin
        eligible_s   = 5'b00000;
        found_s      = 1'b0;
        winner_s     = 3'd0;
        cand_s       = last_owner_r;
        winner_len_s = {LEN_W{1'b0}};
        for (int i = 0; i < 5; i++) begin
            eligible_s[i] = req[i] && (flit_id[3*i +: 3] == HEADER_ID);
        end
        for (int k = 0; k < 5; k++) begin
            cand_s = next_idx(cand_s);
            if (!found_s && ((eligible_s & onehot5(cand_s)) != 5'b00000)) begin
                found_s  = 1'b1;
                winner_s = cand_s;
            end else begin
                found_s  = found_s;
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (winner_s == i[2:0]) begin
                winner_len_s = len[LEN_W*i +: LEN_W];
            end else begin
                winner_len_s = winner_len_s;
            end
        end
    end

    // Owner-side view: its request and the flit type currently at its FIFO head
    always_comb begin
        owner_oh_s   = onehot5(owner_r);
        owner_req_s  = |(req & owner_oh_s);
        owner_flit_s = 3'b000;
        for (int i = 0; i < 5; i++) begin
            if (owner_r == i[2:0]) begin
                owner_flit_s = flit_id[3*i +: 3];
            end else begin
                owner_flit_s = owner_flit_s;
            end
        end
    end

    // Next-state logic; grant is combinational so a flit moves in the same cycle
    always_comb begin
        state_n = state_r;
        owner_n = owner_r;
        cnt_n   = cnt_r;
        last_n  = last_owner_r;
        done_n  = 1'b0;
        grant_s = 5'b00000;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    owner_n = winner_s;
                    cnt_n   = (winner_len_s == {LEN_W{1'b0}}) ? CNT_ONE : winner_len_s;
                    state_n = XFER;
                end else begin
                    state_n = IDLE;
                end
            end
            XFER: begin
                if (owner_req_s && out_ready) begin
                    grant_s = owner_oh_s;
                    cnt_n   = cnt_r - CNT_ONE;
                    if ((cnt_r == CNT_ONE) || (owner_flit_s == TAIL_ID)) begin
                        state_n = IDLE;
                        last_n  = owner_r;
                        done_n  = 1'b1;
                    end else begin
                        state_n = XFER;
                    end
                end else begin
                    grant_s = 5'b00000;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State registers; L gets first priority after reset because last_owner starts at S
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            owner_r      <= 3'd0;
            cnt_r        <= {LEN_W{1'b0}};
            last_owner_r <= 3'd4;
            pkt_done_r   <= 1'b0;
        end else begin
            state_r      <= state_n;
            owner_r      <= owner_n;
            cnt_r        <= cnt_n;
            last_owner_r <= last_n;
            pkt_done_r   <= done_n;
        end
    end

    assign grant    = grant_s;
    assign busy     = (state_r == XFER);
    assign sel      = busy ? owner_oh_s : 5'b00000;
    assign pkt_done = pkt_done_r;

    wormhole_port_arbiter_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .grant    (grant),
        .sel      (sel),
        .busy     (busy),
        .pkt_done (pkt_done)
    );

endmodule

// Structural invariants of the arbiter outputs.
module wormhole_port_arbiter_chk (
    input logic       clk,
    input logic       rst,
    input logic [4:0] grant,
    input logic [4:0] sel,
    input logic       busy,
    input logic       pkt_done
);

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));
    a_grant_in_sel:  assert property (@(posedge clk) disable iff (!rst) (grant & ~sel) == 5'b00000);
    a_sel_busy:      assert property (@(posedge clk) disable iff (!rst) (sel != 5'b00000) == busy);
    a_done_pulse:    assert property (@(posedge clk) disable iff (!rst) pkt_done |=> !pkt_done);

endmodule

// File: tb/tb_wormhole_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-level packet model of the port scheduler.
module tb_wormhole_port_arbiter;

    localparam int         LEN_W = 12;
    localparam logic [2:0] HDR   = 3'b001;
    localparam logic [2:0] BODY  = 3'b010;
    localparam logic [2:0] TAIL  = 3'b100;
    localparam logic [14:0] ALL_HDR = {HDR, HDR, HDR, HDR, HDR};

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [4:0]         req = 5'b00000;
    logic [14:0]        flit_id = 15'd0;
    logic [5*LEN_W-1:0] len = '0;
    logic               out_ready = 1'b0;
    logic [4:0]         grant;
    logic [4:0]         sel;
    logic               busy;
    logic               pkt_done;

    int checks = 0;
    int errors = 0;

    // Reference model: which input holds the port, flits still owed, last served input
    bit m_locked;
    int m_owner;
    int m_left;
    int m_last;
    bit m_done;

    int         n_grants;
    bit         prev_busy;
    logic [4:0] owner_log[$];

    wormhole_port_arbiter #(.HEADER_ID(3'b001), .TAIL_ID(3'b100), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .flit_id   (flit_id),
        .len       (len),
        .out_ready (out_ready),
        .grant     (grant),
        .sel       (sel),
        .busy      (busy),
        .pkt_done  (pkt_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5*LEN_W-1:0] pack_len(input int a, input int b, input int c,
                                                   input int d, input int e);
        return {e[11:0], d[11:0], c[11:0], b[11:0], a[11:0]};
    endfunction

    function automatic logic [14:0] pack_fid(input logic [2:0] a, input logic [2:0] b,
                                             input logic [2:0] c, input logic [2:0] d,
                                             input logic [2:0] e);
        return {e, d, c, b, a};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_grant", {27'd0, grant}, 32'd0);
        check("rst_sel", {27'd0, sel}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, pkt_done}, 32'd0);
        req       = 5'b00000;
        flit_id   = 15'd0;
        len       = '0;
        out_ready = 1'b0;
        m_locked  = 1'b0;
        m_owner   = 0;
        m_left    = 0;
        m_last    = 4;
        m_done    = 1'b0;
        prev_busy = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic step(input logic [4:0] r, input logic [14:0] f,
                        input logic [5*LEN_W-1:0] l, input logic o);
        logic [4:0] exp_grant;
        logic [4:0] exp_sel;
        bit         found;
        int         j;
        int         ln;
        @(negedge clk);
        req       = r;
        flit_id   = f;
        len       = l;
        out_ready = o;
        #1;
        exp_sel   = m_locked ? 5'(1 << m_owner) : 5'b00000;
        exp_grant = (m_locked && r[m_owner] && o) ? exp_sel : 5'b00000;
        check("grant", {27'd0, grant}, {27'd0, exp_grant});
        check("sel", {27'd0, sel}, {27'd0, exp_sel});
        check("busy", {31'd0, busy}, {31'd0, m_locked});
        check("pkt_done", {31'd0, pkt_done}, {31'd0, m_done});
        n_grants += $countones(grant);
        if (busy && !prev_busy) owner_log.push_back(sel);
        prev_busy = busy;
        m_done = 1'b0;
        if (m_locked) begin
            if (exp_grant != 5'b00000) begin
                if (m_left == 1 || f[3*m_owner +: 3] == TAIL) begin
                    m_locked = 1'b0;
                    m_last   = m_owner;
                    m_done   = 1'b1;
                end else begin
                    m_left = m_left - 1;
                end
            end
        end else begin
            found = 1'b0;
            for (int k = 1; k <= 5; k++) begin
                j = (m_last + k) % 5;
                if (!found && r[j] && f[3*j +: 3] == HDR) begin
                    found    = 1'b1;
                    m_locked = 1'b1;
                    m_owner  = j;
                    ln       = int'(l[LEN_W*j +: LEN_W]);
                    m_left   = (ln == 0) ? 1 : ln;
                end
            end
        end
    endtask

    initial begin
        logic [14:0] f;
        logic [5*LEN_W-1:0] l;
        logic [2:0] t;
        #3;
        do_reset();

        // Single requester E, len 4: four grants then release
        n_grants = 0;
        repeat (6) step(5'b00100, ALL_HDR, pack_len(0, 0, 4, 0, 0), 1'b1);
        step(5'b00000, ALL_HDR, '0, 1'b1);
        check("single_grants", n_grants, 32'd4);

        // Round-robin over five len-2 packets from reset
        do_reset();
        owner_log.delete();
        n_grants = 0;
        repeat (18) step(5'b11111, ALL_HDR, pack_len(2, 2, 2, 2, 2), 1'b1);
        check("rr_grants", n_grants, 32'd12);
        check("rr_count", owner_log.size() >= 6, 32'd1);
        for (int k = 0; k < 6; k++) begin
            check("rr_owner", (owner_log.size() > k) ? {27'd0, owner_log[k]} : 32'd0,
                  32'(1 << (k % 5)));
        end

        // Backpressure on W with len 3
        do_reset();
        n_grants = 0;
        step(5'b01000, ALL_HDR, pack_len(0, 0, 0, 3, 0), 1'b1);
        step(5'b01000, ALL_HDR, pack_len(0, 0, 0, 3, 0), 1'b1);
        step(5'b01000, ALL_HDR, pack_len(0, 0, 0, 3, 0), 1'b0);
        step(5'b01000, ALL_HDR, pack_len(0, 0, 0, 3, 0), 1'b0);
        step(5'b01000, ALL_HDR, pack_len(0, 0, 0, 3, 0), 1'b1);
        step(5'b01000, ALL_HDR, pack_len(0, 0, 0, 3, 0), 1'b1);
        step(5'b00000, ALL_HDR, '0, 1'b1);
        check("bp_grants", n_grants, 32'd3);

        // Early tail on S (len 6) after two grants
        do_reset();
        n_grants = 0;
        step(5'b10000, ALL_HDR, pack_len(0, 0, 0, 0, 6), 1'b1);
        step(5'b10000, pack_fid(HDR, HDR, HDR, HDR, HDR), pack_len(0, 0, 0, 0, 6), 1'b1);
        step(5'b10000, pack_fid(HDR, HDR, HDR, HDR, TAIL), pack_len(0, 0, 0, 0, 6), 1'b1);
        step(5'b00000, ALL_HDR, '0, 1'b1);
        check("tail_grants", n_grants, 32'd2);

        // Zero-length packet on L
        n_grants = 0;
        step(5'b00001, ALL_HDR, pack_len(0, 0, 0, 0, 0), 1'b1);
        step(5'b00001, pack_fid(BODY, HDR, HDR, HDR, HDR), pack_len(0, 0, 0, 0, 0), 1'b1);
        step(5'b00000, ALL_HDR, '0, 1'b1);
        step(5'b00000, ALL_HDR, '0, 1'b1);
        check("zero_len_grants", n_grants, 32'd1);

        // Reset in the middle of an N packet, then L must win first
        do_reset();
        repeat (3) step(5'b00010, ALL_HDR, pack_len(0, 5, 0, 0, 0), 1'b1);
        do_reset();
        owner_log.delete();
        repeat (3) step(5'b00011, ALL_HDR, pack_len(1, 1, 0, 0, 0), 1'b1);
        check("post_rst_owner", (owner_log.size() > 0) ? {27'd0, owner_log[0]} : 32'd0, 32'd1);

        // Random traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 5; i++) begin
                case ($urandom_range(0, 3))
                    0:       t = HDR;
                    1:       t = BODY;
                    2:       t = TAIL;
                    default: t = HDR;
                endcase
                f[3*i +: 3]       = t;
                l[LEN_W*i +: LEN_W] = LEN_W'($urandom_range(0, 5));
            end
            step(5'($urandom), f, l, ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
